// File: rtl/dcm_prog_responder.sv
// DCM_CLKGEN programming-port responder: decodes LoadD/LoadM/GO frames, holds active D-1/M-1, models PROGDONE lock delay.
// Latency: GO effects (new values, cfg_update, PROGDONE low) appear one cycle after the GO sample; frame errors one cycle after the offending sample.
// Backpressure: none; the serial link is free-running and PROGDONE is the only status returned to the controller.
// Optional feature macro: DCM_RESPONDER_RANGE_CHECK_EN (GO rejects pending M+1 outside [2, MAXIMUM_MULTIPLIER]).
module dcm_prog_responder #(
    parameter int LOCK_CYCLES        = 64,   // must be >= 1
    parameter int INITIAL_M_S1       = 15,
    parameter int INITIAL_D_S1       = 8,
    parameter int MAXIMUM_MULTIPLIER = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dcm_prog_en,
    input  logic       dcm_prog_data,
    output logic       dcm_prog_done,
    output logic [7:0] divider_s1,
    output logic [7:0] multiplier_s1,
    output logic       cfg_update,
    output logic       frame_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPC   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_END   = 2'd3
    } state_t;

    localparam int CW = $clog2(LOCK_CYCLES + 1);

`ifdef DCM_RESPONDER_RANGE_CHECK_EN
    localparam bit RANGE_CHECK_EN = 1'b1;
`else
    localparam bit RANGE_CHECK_EN = 1'b0;
`endif

    state_t        state_q, state_d;
    logic          opc_q, opc_d;           // 0 = LoadD, 1 = LoadM
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          ovl_q, ovl_d;           // overlong frame already flagged
    logic [7:0]    pend_d_q, pend_d_d;
    logic [7:0]    pend_m_q, pend_m_d;
    logic [7:0]    div_q, div_d;
    logic [7:0]    mul_q, mul_d;
    logic          cfg_q, cfg_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic [CW-1:0] lock_q, lock_d;

    logic          go;
    logic          go_ok;
    logic          m_in_range;
    logic [8:0]    m_plus;

    // Pending multiplier acceptance test for GO; bypassed when the range check is built out
    always_comb begin
        m_plus     = {1'b0, pend_m_q} + 9'd1;
        m_in_range = (m_plus >= 9'd2) && ({23'd0, m_plus} <= 32'(MAXIMUM_MULTIPLIER));
        go_ok      = !RANGE_CHECK_EN || m_in_range;
    end

    // Frame decoder state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame decoder next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dcm_prog_en && dcm_prog_data) begin
                    state_d = ST_OPC;
                end
            end
            ST_OPC: begin
                state_d = dcm_prog_en ? ST_SHIFT : ST_IDLE;
            end
            ST_SHIFT: begin
                if (!dcm_prog_en) begin
                    state_d = ST_IDLE;
                end else if (bit_cnt_q == 3'd7) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                if (!dcm_prog_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame datapath, GO handling, lock counter and pulse outputs
    always_comb begin
        opc_d     = opc_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ovl_d     = ovl_q;
        pend_d_d  = pend_d_q;
        pend_m_d  = pend_m_q;
        div_d     = div_q;
        mul_d     = mul_q;
        cfg_d     = 1'b0;
        err_d     = 1'b0;
        go        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ovl_d = 1'b0;
                go    = dcm_prog_en && !dcm_prog_data;
            end
            ST_OPC: begin
                if (dcm_prog_en) begin
                    opc_d     = dcm_prog_data;
                    bit_cnt_d = 3'd0;
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (dcm_prog_en) begin
                    // LSB first: after eight shifts the first bit sits in bit 0
                    shift_d   = {dcm_prog_data, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_END: begin
                if (dcm_prog_en) begin
                    // Overlong frame: flag once, then wait for en to drop without committing
                    err_d = !ovl_q;
                    ovl_d = 1'b1;
                end else begin
                    if (!ovl_q) begin
                        if (opc_q) begin
                            pend_m_d = shift_q;
                        end else begin
                            pend_d_d = shift_q;
                        end
                    end
                    ovl_d = 1'b0;
                end
            end
            default: ;
        endcase

        lock_d = (lock_q != '0) ? (lock_q - CW'(1)) : '0;

        if (go) begin
            // PROGDONE always runs the full lock sequence, even for a rejected GO
            lock_d = CW'(LOCK_CYCLES);
            if (go_ok) begin
                div_d = pend_d_q;
                mul_d = pend_m_q;
                cfg_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        done_d = (lock_d == '0);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opc_q     <= 1'b0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            ovl_q     <= 1'b0;
            pend_d_q  <= 8'(INITIAL_D_S1);
            pend_m_q  <= 8'(INITIAL_M_S1);
            div_q     <= 8'(INITIAL_D_S1);
            mul_q     <= 8'(INITIAL_M_S1);
            cfg_q     <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b1;
            lock_q    <= '0;
        end else begin
            opc_q     <= opc_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ovl_q     <= ovl_d;
            pend_d_q  <= pend_d_d;
            pend_m_q  <= pend_m_d;
            div_q     <= div_d;
            mul_q     <= mul_d;
            cfg_q     <= cfg_d;
            err_q     <= err_d;
            done_q    <= done_d;
            lock_q    <= lock_d;
        end
    end

    assign dcm_prog_done = done_q;
    assign divider_s1    = div_q;
    assign multiplier_s1 = mul_q;
    assign cfg_update    = cfg_q;
    assign frame_error   = err_q;

endmodule
